// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
// serial_subtractor: bit-serial N-bit subtractor, diff = a0 - a1 - bi.
// A single full-subtractor cell is reused over N cycles, LSB first.
// Operands enter and results leave through valid/ready handshakes.
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] a1,
  input  logic         bi,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bo
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_a0;
  logic [N-1:0]   r_a1;
  logic [N-1:0]   r_diff;
  logic [CW-1:0]  r_count;
  logic           r_borrow;
  logic           r_bo;
  logic           r_out_valid;

  logic           w_x;
  logic           w_y;
  logic           w_d;
  logic           w_borrow_next;
  logic [N-1:0]   w_d_vec;
  logic [N-1:0]   w_diff_next;

  // Full-subtractor cell on the current operand bits; the operands are
  // shifted right each RUN cycle, so bit k = count always sits at the LSB.
  always_comb begin
    w_x           = r_a0[0];
    w_y           = r_a1[0];
    w_d           = w_x ^ w_y ^ r_borrow;
    w_borrow_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
    w_d_vec       = N'(w_d);
    // Result fills from the MSB side so that after N shifts bit 0 is the LSB.
    w_diff_next   = (r_diff >> 1) | (w_d_vec << (N - 1));
  end

  // Control FSM plus the operand, result and borrow datapath registers.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a0        <= '0;
      r_a1        <= '0;
      r_diff      <= '0;
      r_count     <= '0;
      r_borrow    <= 1'b0;
      r_bo        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a0     <= a0;
            r_a1     <= a1;
            r_borrow <= bi;
            r_count  <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_a0     <= r_a0 >> 1;
          r_a1     <= r_a1 >> 1;
          r_diff   <= w_diff_next;
          r_borrow <= w_borrow_next;
          r_count  <= r_count + CW'(1);
          if (r_count == LAST_BIT) begin
            r_bo        <= w_borrow_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // Result is held until the consumer takes it; accept waits a cycle.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bo        = r_bo;

endmodule
